// File: rtl/vce_pkg.sv
// Shared types and helpers for the video color encoder: register map,
// dot-clock modes, packed color entry and channel expansion.
package vce_pkg;

  localparam int unsigned MAX_W = 16;
  localparam int unsigned IDX_W = 4;

  typedef enum logic [2:0] {
    CTRL   = 3'd0,
    CTA_LO = 3'd2,
    CTA_HI = 3'd3,
    CTW_LO = 3'd4,
    CTW_HI = 3'd5
  } reg_sel_e;

  typedef enum logic [1:0] {
    DOT_M0 = 2'd0,
    DOT_M1 = 2'd1,
    DOT_M2 = 2'd2,
    DOT_M3 = 2'd3
  } dot_mode_e;

  typedef struct packed {
    logic [MAX_W-1:0] g;
    logic [MAX_W-1:0] r;
    logic [MAX_W-1:0] b;
  } color_t;

  // Widen an in_w-bit channel to out_w bits by repeating it MSB-first.
  function automatic logic [MAX_W-1:0] expand_ch(input logic [MAX_W-1:0] v,
                                                 input int unsigned in_w,
                                                 input int unsigned out_w);
    logic [MAX_W-1:0] res;
    res = '0;
    for (int unsigned j = 0; j < MAX_W; j++) begin
      if (j < out_w) res[IDX_W'(out_w - 1 - j)] = v[IDX_W'(in_w - 1 - (j % in_w))];
    end
    return res;
  endfunction

endpackage

// File: rtl/vce_dot_clk.sv
// Programmable dot-clock divider; the half-period reload is picked per mode
// only when the counter expires, so a mode change never produces a runt dot.
module vce_dot_clk
  import vce_pkg::*;
#(
  parameter int unsigned DIV0 = 8,
  parameter int unsigned DIV1 = 6,
  parameter int unsigned DIV2 = 4
) (
  input  logic      clk,
  input  logic      reset_N,
  input  dot_mode_e mode,
  output logic      CK,
  output logic      ck_en
);

  logic [7:0] cnt;
  logic [7:0] reload;

  always_comb begin
    reload = '0;
    case (mode)
      DOT_M0:  reload = 8'(DIV0 / 2 - 1);
      DOT_M1:  reload = 8'(DIV1 / 2 - 1);
      default: reload = 8'(DIV2 / 2 - 1);
    endcase
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      cnt   <= '0;
      CK    <= 1'b0;
      ck_en <= 1'b0;
    end else if (cnt == '0) begin
      cnt   <= reload;
      CK    <= ~CK;
      ck_en <= ~CK;
    end else begin
      cnt   <= cnt - 8'd1;
      ck_en <= 1'b0;
    end
  end

endmodule

// File: rtl/vce_palette_engine.sv
// Video color encoder top: CPU register port, color table RAM and a
// three-stage pixel pipeline clocked by the dot-clock enable.
module vce_palette_engine
  import vce_pkg::*;
#(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned CH_W   = 3,
  parameter int unsigned OUT_W  = 8,
  parameter int unsigned DIV0   = 8,
  parameter int unsigned DIV1   = 6,
  parameter int unsigned DIV2   = 4
) (
  input  logic              clk,
  input  logic              reset_N,
  input  logic              CS_n,
  input  logic              WR_n,
  input  logic              RD_n,
  input  logic [2:0]        A,
  input  logic [7:0]        D_in,
  output logic [7:0]        D_out,
  input  logic [ADDR_W-1:0] VD,
  input  logic              HSYN_n,
  input  logic              VSYN_n,
  output logic              CK,
  output logic              ck_en,
  output logic [OUT_W-1:0]  VIDEO_R,
  output logic [OUT_W-1:0]  VIDEO_G,
  output logic [OUT_W-1:0]  VIDEO_B
);

  localparam int unsigned ENT_W = 3 * CH_W;
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [ENT_W-1:0]  cram [DEPTH];
  dot_mode_e         mode;
  logic [ADDR_W-1:0] cta;
  logic [7:0]        lo_q;
  logic              wr_q, rd_q, wr_det, rd_det, cram_we;

  logic [ADDR_W-1:0] vd_q;
  logic              v0, v1, blank0, blank1;
  logic [ENT_W-1:0]  ent_q;
  color_t            pix;

  vce_dot_clk #(.DIV0(DIV0), .DIV1(DIV1), .DIV2(DIV2)) u_dot_clk (
    .clk     (clk),
    .reset_N (reset_N),
    .mode    (mode),
    .CK      (CK),
    .ck_en   (ck_en)
  );

  assign wr_det  = ~CS_n & ~WR_n & ~wr_q;
  assign rd_det  = ~CS_n & ~RD_n & ~rd_q;
  assign cram_we = wr_det && (A == CTW_HI);

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      mode  <= DOT_M0;
      cta   <= '0;
      lo_q  <= '0;
      D_out <= '0;
    end else begin
      wr_q <= ~CS_n & ~WR_n;
      rd_q <= ~CS_n & ~RD_n;
      if (wr_det) begin
        case (A)
          CTRL:    mode <= dot_mode_e'(D_in[1:0]);
          CTA_LO:  cta[7:0] <= D_in;
          CTA_HI:  cta[ADDR_W-1:8] <= D_in[ADDR_W-9:0];
          CTW_LO:  lo_q <= D_in;
          CTW_HI:  cta <= cta + ADDR_W'(1);
          default: ;
        endcase
      end
      if (rd_det) begin
        case (A)
          CTW_LO:  D_out <= cram[cta][7:0];
          CTW_HI: begin
            // bits above the entry width read back as ones
            D_out <= 8'(((16'hFFFF << ENT_W) | 16'(cram[cta])) >> 8);
            cta   <= cta + ADDR_W'(1);
          end
          default: D_out <= 8'hFF;
        endcase
      end
    end
  end

  // No reset on the array: a write caught by reset is simply dropped.
  always_ff @(posedge clk) begin
    if (reset_N && cram_we) cram[cta] <= ENT_W'({D_in, lo_q});
  end

  always_comb begin
    pix   = '0;
    pix.g = MAX_W'(ent_q[2*CH_W +: CH_W]);
    pix.r = MAX_W'(ent_q[CH_W +: CH_W]);
    pix.b = MAX_W'(ent_q[0 +: CH_W]);
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      vd_q    <= '0;
      v0      <= 1'b0;
      v1      <= 1'b0;
      blank0  <= 1'b0;
      blank1  <= 1'b0;
      ent_q   <= '0;
      VIDEO_R <= '0;
      VIDEO_G <= '0;
      VIDEO_B <= '0;
    end else if (ck_en) begin
      vd_q   <= VD;
      blank0 <= ~HSYN_n | ~VSYN_n;
      v0     <= 1'b1;
      ent_q  <= cram[vd_q];
      blank1 <= blank0;
      v1     <= v0;
      if (v1 && !blank1) begin
        VIDEO_R <= OUT_W'(expand_ch(pix.r, CH_W, OUT_W));
        VIDEO_G <= OUT_W'(expand_ch(pix.g, CH_W, OUT_W));
        VIDEO_B <= OUT_W'(expand_ch(pix.b, CH_W, OUT_W));
      end else begin
        VIDEO_R <= '0;
        VIDEO_G <= '0;
        VIDEO_B <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vce_palette_engine.sv
// Directed bench for vce_palette_engine: dot clock, register port, color
// table wrap, pixel latency, sync blanking, collisions and async reset.
module tb_vce_palette_engine;

  logic       clk = 1'b0;
  logic       reset_N;
  logic       CS_n, WR_n, RD_n;
  logic [2:0] A;
  logic [7:0] D_in;
  logic [7:0] D_out;
  logic [8:0] VD;
  logic       HSYN_n, VSYN_n;
  logic       CK, ck_en;
  logic [7:0] VIDEO_R, VIDEO_G, VIDEO_B;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc, hi;
  logic [7:0] rdat;

  vce_palette_engine #(
    .ADDR_W(9), .CH_W(3), .OUT_W(8), .DIV0(8), .DIV1(6), .DIV2(4)
  ) dut (
    .clk(clk), .reset_N(reset_N), .CS_n(CS_n), .WR_n(WR_n), .RD_n(RD_n),
    .A(A), .D_in(D_in), .D_out(D_out), .VD(VD), .HSYN_n(HSYN_n),
    .VSYN_n(VSYN_n), .CK(CK), .ck_en(ck_en),
    .VIDEO_R(VIDEO_R), .VIDEO_G(VIDEO_G), .VIDEO_B(VIDEO_B)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    A = a; D_in = d; CS_n = 1'b0; WR_n = 1'b0;
    @(negedge clk);
    CS_n = 1'b1; WR_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] d);
    A = a; CS_n = 1'b0; RD_n = 1'b0;
    @(negedge clk);
    d = D_out;
    CS_n = 1'b1; RD_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_pulse;
    logic found;
    found = 1'b0;
    for (int i = 0; i < 32 && !found; i++) begin
      @(negedge clk);
      found = ck_en;
    end
    chk("pulse_seen", 32'(found), 32'd1);
  endtask

  // Called on a sample with ck_en=1; counts clks to the next ck_en and CK-high samples.
  task automatic measure(output int c, output int h);
    logic done;
    c = 0; h = 0; done = 1'b0;
    while (!done && c < 64) begin
      if (CK) h++;
      @(negedge clk);
      c++;
      done = ck_en;
    end
  endtask

  initial begin
    reset_N = 1'b0; CS_n = 1'b1; WR_n = 1'b1; RD_n = 1'b1;
    A = '0; D_in = '0; VD = '0; HSYN_n = 1'b1; VSYN_n = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("rst_CK", 32'(CK), 32'd0);
    chk("rst_cken", 32'(ck_en), 32'd0);
    chk("rst_rgb", 32'({VIDEO_G, VIDEO_R, VIDEO_B}), 32'h0);
    chk("rst_dout", 32'(D_out), 32'h00);

    reset_N = 1'b1;
    @(negedge clk);
    chk("first_CK", 32'(CK), 32'd1);
    chk("first_cken", 32'(ck_en), 32'd1);
    measure(cyc, hi);
    chk("m0_period", 32'(cyc), 32'd8);
    chk("m0_high", 32'(hi), 32'd4);

    // mode 2 lands mid high-phase: current half finishes at 4, low half uses 2
    A = 3'd0; D_in = 8'h02; CS_n = 1'b0; WR_n = 1'b0;
    measure(cyc, hi);
    chk("switch_period", 32'(cyc), 32'd6);
    chk("switch_high", 32'(hi), 32'd4);
    CS_n = 1'b1; WR_n = 1'b1;
    measure(cyc, hi);
    chk("m2_period", 32'(cyc), 32'd4);
    chk("m2_high", 32'(hi), 32'd2);

    // table write at the top address, CTA wraps to 0
    wr(3'd2, 8'hFF); wr(3'd3, 8'h01);
    wr(3'd4, 8'hA5); wr(3'd5, 8'h01);
    wr(3'd4, 8'h33); wr(3'd5, 8'h00);
    wr(3'd2, 8'hFF); wr(3'd3, 8'h01);
    rd(3'd4, rdat); chk("rd_lo_1FF", 32'(rdat), 32'hA5);
    rd(3'd5, rdat); chk("rd_hi_1FF", 32'(rdat), 32'hFF);
    rd(3'd4, rdat); chk("rd_lo_wrap0", 32'(rdat), 32'h33);
    rd(3'd5, rdat); chk("rd_hi_0", 32'(rdat), 32'hFE);
    rd(3'd6, rdat); chk("rd_unused", 32'(rdat), 32'hFF);

    // index 3 = 111_000_101
    wr(3'd2, 8'h03); wr(3'd3, 8'h00);
    wr(3'd4, 8'hC5); wr(3'd5, 8'h01);
    wait_pulse;
    VD = 9'd3;
    wait_pulse;
    wait_pulse;
    chk("pix_old", 32'({VIDEO_G, VIDEO_R, VIDEO_B}), 32'h00DB6D);
    wait_pulse;
    chk("pix_idx3", 32'({VIDEO_G, VIDEO_R, VIDEO_B}), 32'hFF00B6);

    wait_pulse;
    VSYN_n = 1'b0;
    wait_pulse;
    VSYN_n = 1'b1;
    wait_pulse;
    chk("sync_before", 32'({VIDEO_G, VIDEO_R, VIDEO_B}), 32'hFF00B6);
    wait_pulse;
    chk("sync_blank", 32'({VIDEO_G, VIDEO_R, VIDEO_B}), 32'h000000);
    wait_pulse;
    chk("sync_after", 32'({VIDEO_G, VIDEO_R, VIDEO_B}), 32'hFF00B6);

    // address 5: old 1C0, new 007 written on the same edge the pixel reads it
    wr(3'd2, 8'h05); wr(3'd3, 8'h00);
    wr(3'd4, 8'hC0); wr(3'd5, 8'h01);
    wr(3'd2, 8'h05); wr(3'd4, 8'h07);
    wait_pulse;
    VD = 9'd5;
    wait_pulse;
    A = 3'd5; D_in = 8'h00; CS_n = 1'b0; WR_n = 1'b0;
    wait_pulse;
    CS_n = 1'b1; WR_n = 1'b1;
    wait_pulse;
    chk("coll_old", 32'({VIDEO_G, VIDEO_R, VIDEO_B}), 32'hFF0000);
    wait_pulse;
    chk("coll_new", 32'({VIDEO_G, VIDEO_R, VIDEO_B}), 32'h0000FF);

    // reset in the middle of a read
    wr(3'd2, 8'h05);
    A = 3'd4; CS_n = 1'b0; RD_n = 1'b0;
    @(negedge clk);
    chk("burst_rd", 32'(D_out), 32'h07);
    #2 reset_N = 1'b0;
    #1;
    chk("arst_dout", 32'(D_out), 32'h00);
    chk("arst_CK", 32'(CK), 32'd0);
    chk("arst_cken", 32'(ck_en), 32'd0);
    chk("arst_rgb", 32'({VIDEO_G, VIDEO_R, VIDEO_B}), 32'h0);
    CS_n = 1'b1; RD_n = 1'b1;
    @(negedge clk);
    reset_N = 1'b1;
    wait_pulse;
    measure(cyc, hi);
    chk("post_rst_period", 32'(cyc), 32'd8);
    wr(3'd4, 8'h5A); wr(3'd5, 8'h00);
    wr(3'd2, 8'h00); wr(3'd3, 8'h00);
    rd(3'd4, rdat); chk("post_rst_cta0", 32'(rdat), 32'h5A);
    rd(3'd5, rdat); chk("post_rst_hi", 32'(rdat), 32'hFE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/vce_palette_engine.md
# vce_palette_engine

Parametrised next-generation video color encoder core. Takes palette indices from the VDC, looks them up in an internal color table RAM, and drives expanded RGB plus a programmable dot clock. The CPU programs the table and mode through a byte-wide register port. Sits between the VDC pixel bus and the video output stage.

## Interface
- `ADDR_W`, 9: color table address width; the table has 2^ADDR_W entries.
- `CH_W`, 3: bits per color channel. Entry width is `3*CH_W`, packed as G (top), R, B (bottom).
- `OUT_W`, 8: output channel width, with `OUT_W >= CH_W`.
- `DIV0`/`DIV1`/`DIV2`, 8/6/4: `clk` cycles per dot for modes 0, 1 and 2/3. Each must be even and ≥ 2.

Ports:
- `clk`  in  1  system clock at twice the console master clock.
- `reset_N`  in  1  asynchronous, active-low reset.
- `CS_n`, `WR_n`, `RD_n`  in  1 each  CPU strobes, active low.
- `A`  in  3  register select.
- `D_in`  in  8  CPU write data.
- `D_out`  out  8  CPU read data.
- `VD`  in  ADDR_W  pixel palette index from the VDC.
- `HSYN_n`, `VSYN_n`  in  1 each  sync inputs, active low.
- `CK`  out  1  dot clock, level output.
- `ck_en`  out  1  one-`clk` pulse at each `CK` rising edge.
- `VIDEO_R`, `VIDEO_G`, `VIDEO_B`  out  OUT_W each  pixel color.

## Operation
- **Access edge detection:**
  - A write occurs on the first `clk` where `CS_n=0 && WR_n=0`. The strobe must deassert before the next write.
  - A read access is detected the same way, on the first `clk` where `CS_n=0 && RD_n=0`.
- **Registers:**
  - A=0, write: `mode <= D_in[1:0]`.
  - A=2 / A=3, write: color table address `CTA` low byte / high bits `[ADDR_W-9:0]`.
  - A=4, write: latch `lo_q <= D_in`. Read: `CRAM[CTA][7:0]`.
  - A=5, write: `CRAM[CTA] <= {D_in, lo_q}` (truncated to the entry width), then `CTA <= CTA+1`, wrapping at 2^ADDR_W.
  - A=5, read: the high bits of `CRAM[CTA]`, with unused bits read as 1, then `CTA` increments.
  - A=1, 6, 7: writes are ignored and reads return `0xFF`.
- **D_out:** registered. It is updated on the detected read cycle with the pre-increment `CTA` and holds otherwise.
- **Dot clock (sub-module):**
  - The down-counter reloads with `DIVn/2-1` when it reaches 0, and `CK` toggles at the same time.
  - `ck_en` asserts on the 0→1 toggle.
  - A new `mode` is applied only at the next reload, so there are no runt dots.
- **Pixel pipeline:** advances only when `ck_en=1`.
  - S0: register `VD` and the sync state.
  - S1: synchronous CRAM read.
  - S2: expand each channel to OUT_W by MSB-first bit replication; for example, 3'b101 becomes 8'b10110110.
  - If either sync input was low at S0, the outputs are forced to 0.
- **Collision:** a CPU write and a pixel read to the same address in the same cycle returns the old data to the pixel read (read-first).

## Timing
- **Reset values:**
  - `CK=0`, `ck_en=0`, RGB=0, `D_out=0x00`.
  - `mode=0`, `CTA=0`, `lo_q=0`, divider counter=0, pipeline valid/sync state cleared.
  - CRAM contents are undefined.
- After reset release, the first `clk` edge toggles `CK` to 1 with `ck_en=1`. After that the period is `DIVn` clks with a 50% duty cycle.
- **Pixel latency:** `VD` sampled at `ck_en` pulse k appears on RGB after pulse k+2 and holds until pulse k+3.
- **CPU timing:**
  - A write to CRAM is visible to a CPU read starting on the next `clk`.
  - `D_out` is valid 1 `clk` after the read is detected.
- `CTA` wrap: writing at address 2^ADDR_W−1 advances `CTA` to 0.
- Reset asserted mid-operation immediately clears all registers and outputs. Any in-flight CRAM write is discarded.

## Structure
- Package `vce_pkg` holds:
  - the register-select enum (`CTRL`, `CTA_LO`, `CTA_HI`, `CTW_LO`, `CTW_HI`);
  - the dot-mode enum;
  - the channel-expansion function;
  - the packed color struct {g, r, b}.
- Sub-module `vce_dot_clk` contains the generalised divider. Its inputs are `clk`, `reset_N`, `mode`, and the DIV parameters. Its outputs are `CK` and `ck_en`.
- The CRAM is an inferred dual-port array: one CPU read/write port and one pixel read port.

## Test plan
- **Reset, then mode 0, then mode 2 written mid-period:**
  - Required: `CK` period of 8 clks, then 4 clks.
  - Required: the switch happens only at a reload, with no pulse shorter than 2 clks.
- **Write CTA=0x1FF, then A4←0xA5, then A5←0x01:**
  - Required: `CRAM[0x1FF]=0x1A5` and `CTA` wraps to 0.
  - Required: reading A4/A5 back at 0x1FF returns `0xA5` / `0xFF`.
- **Load index 3 = 9'b111_000_101, drive `VD=3` with syncs high:**
  - Required: 2 pulses later, G=`0xFF`, R=`0x00`, B=`0xB6`.
- **Drive `VSYN_n=0` with a nonzero entry selected:**
  - Required: RGB=0 for exactly the dots sampled while sync was low.
- **Same-cycle CPU write and pixel read of address 5:**
  - Required: the pixel gets the old color, and the next dot gets the new color.
- **Assert `reset_N` in the middle of a read burst:**
  - Required: all outputs return to their reset values asynchronously.
  - Required: `CTA=0` after release.
